// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clock_in cycles,
// flagging whether the period is within tolerance of EXPECTED and whether the signal was lost.
module clk_period_meter #(
  parameter int unsigned      WIDTH     = 28,
  parameter logic [WIDTH-1:0] EXPECTED  = WIDTH'(107296),
  parameter logic [WIDTH-1:0] TOLERANCE = WIDTH'(16),
  parameter logic [WIDTH-1:0] TIMEOUT   = WIDTH'(1000000)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             timeout
);

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hlatch_q, hlatch_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             freq_ok_q, freq_ok_d;
  logic             timeout_q, timeout_d;

  logic             rise_c;
  logic             fall_c;
  logic             cnt_sat_c;
  logic [WIDTH-1:0] cnt_inc_c;
  logic [WIDTH-1:0] dev_c;
  logic             in_range_c;

  // Three-flop chain: two for metastability, the third for edge detection
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_c = sync2_q & ~sync3_q;
  assign fall_c = ~sync2_q & sync3_q;

  // Counter saturates at TIMEOUT so a stuck signal never wraps into a bogus period
  assign cnt_sat_c = (cnt_q == TIMEOUT);
  assign cnt_inc_c = cnt_sat_c ? cnt_q : cnt_q + WIDTH'(1);

  // Absolute deviation without underflow; both bounds inclusive
  assign dev_c      = (cnt_q >= EXPECTED) ? (cnt_q - EXPECTED) : (EXPECTED - cnt_q);
  assign in_range_c = (dev_c <= TOLERANCE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hlatch_d     = hlatch_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    freq_ok_d    = freq_ok_q;
    timeout_d    = timeout_q;

    case (state_q)
      WAIT_EDGE: begin
        cnt_d = cnt_inc_c;
        if (rise_c) begin
          cnt_d    = WIDTH'(1);
          hlatch_d = '0;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        cnt_d = cnt_inc_c;
        if (fall_c) begin
          hlatch_d = cnt_q;
        end
        if (rise_c) begin
          period_d     = cnt_q;
          high_time_d  = hlatch_q;
          meas_valid_d = 1'b1;
          freq_ok_d    = in_range_c;
          timeout_d    = 1'b0;
          cnt_d        = WIDTH'(1);
          hlatch_d     = '0;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase

    // Loss of signal; a rise in the same cycle takes priority
    if (cnt_sat_c && !rise_c) begin
      timeout_d = 1'b1;
      freq_ok_d = 1'b0;
      state_d   = WAIT_EDGE;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_EDGE;
      cnt_q        <= '0;
      hlatch_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      freq_ok_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hlatch_q     <= hlatch_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      freq_ok_q    <= freq_ok_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign freq_ok    = freq_ok_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: a main instance (EXPECTED=100, TOL=2, TIMEOUT=500)
// and a second instance fed by a divide-by-10 square wave (EXPECTED=10, TOL=0).
module tb_clk_period_meter;
  localparam int unsigned W = 28;

  typedef struct {
    logic [W-1:0] per;
    logic [W-1:0] high;
    logic         fok;
  } exp_t;

  logic clk = 1'b0;
  logic rst, sig, rst_div, sig_div;
  logic [W-1:0] period, high_time;
  logic meas_valid, freq_ok, timeout;
  logic [W-1:0] d_period, d_high;
  logic d_mv, d_fok, d_to;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int meas_cnt = 0;
  int to_seen = 0;
  int div_meas = 0;
  int last_mv_cyc = 0;
  int n_pushed = 0;
  logic [W-1:0] exp_last_period = '0;
  bit expect_to = 1'b0;
  bit have_prev = 1'b0;
  int prev_len = 0;
  int prev_high = 0;
  exp_t sb_q[$];

  clk_period_meter #(
    .WIDTH(W), .EXPECTED(W'(100)), .TOLERANCE(W'(2)), .TIMEOUT(W'(500))
  ) u_dut (
    .clock_in(clk), .reset(rst), .sig_in(sig),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .freq_ok(freq_ok), .timeout(timeout)
  );

  clk_period_meter #(
    .WIDTH(W), .EXPECTED(W'(10)), .TOLERANCE(W'(0)), .TIMEOUT(W'(500))
  ) u_div (
    .clock_in(clk), .reset(rst_div), .sig_in(sig_div),
    .period(d_period), .high_time(d_high), .meas_valid(d_mv),
    .freq_ok(d_fok), .timeout(d_to)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_range(input int len);
    int dev;
    dev = (len >= 100) ? len - 100 : 100 - len;
    return dev <= 2;
  endfunction

  // One high/low cycle of sig; its rise completes the previous period's measurement
  task automatic pulse(input int h, input int l);
    if (have_prev) begin
      sb_q.push_back('{per: W'(prev_len), high: W'(prev_high), fok: in_range(prev_len)});
      n_pushed++;
    end
    sig = 1'b1;
    repeat (h) @(negedge clk);
    sig = 1'b0;
    repeat (l) @(negedge clk);
    prev_len  = h + l;
    prev_high = h;
    have_prev = 1'b1;
  endtask

  // Divide-by-10 source: 5 cycles high, 5 low
  initial begin
    sig_div = 1'b0;
    forever begin
      repeat (5) @(negedge clk);
      sig_div = ~sig_div;
    end
  end

  // Main monitor: pops the scoreboard on every meas_valid and tracks timeout onset
  initial begin
    exp_t e;
    logic mv_prev;
    logic to_prev;
    mv_prev = 1'b0;
    to_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (meas_valid) begin
          meas_cnt++;
          check("mv_single_cycle", 32'(mv_prev), 32'(0));
          if (sb_q.size() == 0) begin
            check("unexpected_meas", 32'(period), 32'(0));
          end else begin
            e = sb_q.pop_front();
            check("period", 32'(period), 32'(e.per));
            check("high_time", 32'(high_time), 32'(e.high));
            check("freq_ok", 32'(freq_ok), 32'(e.fok));
            check("timeout_at_meas", 32'(timeout), 32'(0));
            exp_last_period = e.per;
          end
          last_mv_cyc = cyc;
        end
        if (timeout && !to_prev) begin
          to_seen++;
          check("timeout_expected", 32'(expect_to), 32'(1));
          check("timeout_delay", 32'(cyc - last_mv_cyc), 32'(500));
          check("timeout_period_hold", 32'(period), 32'(exp_last_period));
          check("timeout_freq_ok", 32'(freq_ok), 32'(0));
        end
      end
      mv_prev = meas_valid;
      to_prev = timeout;
    end
  end

  // Divider-path monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_div && d_mv) begin
        div_meas++;
        check("div_period", 32'(d_period), 32'(10));
        check("div_high_time", 32'(d_high), 32'(5));
        check("div_freq_ok", 32'(d_fok), 32'(1));
        check("div_timeout", 32'(d_to), 32'(0));
      end
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rst_div = 1'b1;
    sig = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", 32'(period), 32'(0));
    check("rst_high_time", 32'(high_time), 32'(0));
    check("rst_meas_valid", 32'(meas_valid), 32'(0));
    check("rst_freq_ok", 32'(freq_ok), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    rst = 1'b0;
    rst_div = 1'b0;

    // First rise alone produces nothing; second rise 64 cycles later measures 64
    pulse(32, 32);
    check("first_rise_no_meas", 32'(meas_cnt), 32'(0));
    pulse(50, 50);
    repeat (3) pulse(50, 50);

    // Tolerance boundaries 98, 102, 97, 103
    pulse(49, 49);
    pulse(51, 51);
    pulse(48, 49);
    pulse(51, 52);
    pulse(50, 50);

    // Signal stops after a 100-cycle period
    expect_to = 1'b1;
    pulse(50, 600);
    check("timeout_seen", 32'(to_seen), 32'(1));
    check("timeout_level", 32'(timeout), 32'(1));
    check("timeout_keep_period", 32'(period), 32'(100));
    check("timeout_keep_high", 32'(high_time), 32'(50));
    expect_to = 1'b0;
    have_prev = 1'b0;

    // Recovery: first rise gives no measurement and timeout stays set
    pulse(50, 50);
    check("recover_timeout_held", 32'(timeout), 32'(1));
    check("recover_no_meas", 32'(meas_cnt), 32'(n_pushed));
    pulse(50, 50);
    check("recover_timeout_clear", 32'(timeout), 32'(0));
    pulse(50, 50);

    // Asynchronous reset 30 cycles into a period
    sb_q.push_back('{per: W'(prev_len), high: W'(prev_high), fok: in_range(prev_len)});
    n_pushed++;
    sig = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_reset_period", 32'(period), 32'(100));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_period", 32'(period), 32'(0));
    check("mid_rst_high_time", 32'(high_time), 32'(0));
    check("mid_rst_meas_valid", 32'(meas_valid), 32'(0));
    check("mid_rst_freq_ok", 32'(freq_ok), 32'(0));
    check("mid_rst_timeout", 32'(timeout), 32'(0));
    repeat (20) @(negedge clk);
    sig = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    have_prev = 1'b0;
    repeat (40) @(negedge clk);
    repeat (4) pulse(50, 50);
    repeat (10) @(negedge clk);

    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    check("meas_count", 32'(meas_cnt), 32'(n_pushed));
    check("div_meas_seen", 32'(div_meas > 100), 32'(1));
    check("div_freq_ok_level", 32'(d_fok), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
